// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_plus4_o,
   output logic        if_id_valid_o,
   output logic        exc_o,
   output logic [31:0] epc_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pp4_q, pp4_d;
   logic        valid_q, valid_d;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pp4_d   = pp4_q;
      valid_d = valid_q;
      if (redirect_i) begin
         pc_d    = {redirect_pc_i[31:2], 2'b00};
         instr_d = NOP_INSTR;
         pp4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (!stall_i) begin
         pc_d    = pc_plus4_i;
         instr_d = imem_rdata_i;
         pp4_d   = pc_plus4_i;
         valid_d = 1'b1;
      end
`ifdef IF_MISALIGN_TRAP_EN
      if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
         pc_d = EXC_VECTOR;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pp4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pp4_q   <= pp4_d;
         valid_q <= valid_d;
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   logic        exc_q, exc_d;
   logic [31:0] epc_q, epc_d;

   // exc is a one-cycle pulse; epc sticks until the next trap
   always_comb begin
      exc_d = 1'b0;
      epc_d = epc_q;
      if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
         exc_d = 1'b1;
         epc_d = redirect_pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_q <= 1'b0;
         epc_q <= 32'h0;
      end else begin
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   assign exc_o = exc_q;
   assign epc_o = epc_q;
`else
   logic unused_ok;
   assign unused_ok = ^{EXC_VECTOR, redirect_pc_i[1:0]};
   assign exc_o = 1'b0;
   assign epc_o = 32'h0;
`endif

   assign pc_o             = pc_q;
   assign imem_addr_o      = pc_q;
   assign if_id_instr_o    = instr_q;
   assign if_id_pc_plus4_o = pp4_q;
   assign if_id_valid_o    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free run, stall, redirect, wrap,
// misaligned redirect and asynchronous reset mid-stall.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_plus4_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] imem_addr_o;
   logic [31:0] if_id_instr_o;
   logic [31:0] if_id_pc_plus4_o;
   logic        if_id_valid_o;
   logic        exc_o;
   logic [31:0] epc_o;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // environment: PC+4 adder and instruction memory
   assign pc_plus4_i   = pc_o + 32'd4;
   assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

   if_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_i          (stall_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .pc_plus4_i       (pc_plus4_i),
      .imem_rdata_i     (imem_rdata_i),
      .pc_o             (pc_o),
      .imem_addr_o      (imem_addr_o),
      .if_id_instr_o    (if_id_instr_o),
      .if_id_pc_plus4_o (if_id_pc_plus4_o),
      .if_id_valid_o    (if_id_valid_o),
      .exc_o            (exc_o),
      .epc_o            (epc_o)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag,
                          input logic [31:0] pc,
                          input logic [31:0] ins,
                          input logic [31:0] pp4,
                          input logic        vld);
      chk({tag, ".pc"}, pc_o, pc);
      chk({tag, ".addr"}, imem_addr_o, pc);
      chk({tag, ".instr"}, if_id_instr_o, ins);
      chk({tag, ".pp4"}, if_id_pc_plus4_o, pp4);
      chk({tag, ".valid"}, {31'h0, if_id_valid_o}, {31'h0, vld});
   endtask

   localparam logic [31:0] K = 32'hA5A5_0000;

   initial begin
      rst_n         = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      #1;
      chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("rst.exc", {31'h0, exc_o}, 32'h0);
      chk("rst.epc", epc_o, 32'h0);
      edge1();
      chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;

      // free run
      edge1(); chk_all("run1", 32'h4, K ^ 32'h0, 32'h4, 1'b1);
      edge1(); chk_all("run2", 32'h8, K ^ 32'h4, 32'h8, 1'b1);

      // stall 3 cycles at pc=8
      stall_i = 1'b1;
      edge1(); chk_all("stall1", 32'h8, K ^ 32'h4, 32'h8, 1'b1);
      edge1(); chk_all("stall2", 32'h8, K ^ 32'h4, 32'h8, 1'b1);
      edge1(); chk_all("stall3", 32'h8, K ^ 32'h4, 32'h8, 1'b1);
      stall_i = 1'b0;
      edge1(); chk_all("resume1", 32'hC, K ^ 32'h8, 32'hC, 1'b1);
      edge1(); chk_all("resume2", 32'h10, K ^ 32'hC, 32'h10, 1'b1);

      // redirect wins over simultaneous stall
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h40;
      edge1(); chk_all("redir", 32'h40, 32'h0, 32'h0, 1'b0);
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      edge1(); chk_all("redir_next", 32'h44, K ^ 32'h40, 32'h44, 1'b1);

      // wrap from the top of the address space
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      edge1(); chk_all("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      redirect_i = 1'b0;
      edge1(); chk_all("wrap", 32'h0, K ^ 32'hFFFF_FFFC, 32'h0, 1'b1);
      chk("wrap.exc", {31'h0, exc_o}, 32'h0);

      // misaligned redirect
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h42;
      edge1();
`ifdef IF_MISALIGN_TRAP_EN
      chk_all("mis", 32'h80, 32'h0, 32'h0, 1'b0);
      chk("mis.exc", {31'h0, exc_o}, 32'h1);
      chk("mis.epc", epc_o, 32'h42);
`else
      chk_all("mis", 32'h40, 32'h0, 32'h0, 1'b0);
      chk("mis.exc", {31'h0, exc_o}, 32'h0);
      chk("mis.epc", epc_o, 32'h0);
`endif
      redirect_i = 1'b0;
      edge1();
`ifdef IF_MISALIGN_TRAP_EN
      chk_all("mis_next", 32'h84, K ^ 32'h80, 32'h84, 1'b1);
      chk("mis_next.exc", {31'h0, exc_o}, 32'h0);
      chk("mis_next.epc", epc_o, 32'h42);
`else
      chk_all("mis_next", 32'h44, K ^ 32'h40, 32'h44, 1'b1);
      chk("mis_next.exc", {31'h0, exc_o}, 32'h0);
      chk("mis_next.epc", epc_o, 32'h0);
`endif

      // async reset while stalled at pc=0x20
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h1C;
      edge1();
      redirect_i = 1'b0;
      edge1(); chk_all("pre_rst", 32'h20, K ^ 32'h1C, 32'h20, 1'b1);
      stall_i = 1'b1;
      edge1(); chk_all("pre_rst_stall", 32'h20, K ^ 32'h1C, 32'h20, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
      chk("async_rst.exc", {31'h0, exc_o}, 32'h0);
      chk("async_rst.epc", epc_o, 32'h0);
      edge1();
      rst_n   = 1'b1;
      stall_i = 1'b0;
      edge1(); chk_all("post_rst", 32'h4, K ^ 32'h0, 32'h4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
